// File: rtl/accel_time_pkg.sv
// Shared types and the quadrature (Gray) step decoder for the accelerometer
// pickoff time processor.
package accel_time_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  // Map {Q,R} onto a 2-bit phase index (00,01,11,10 -> 0,1,2,3) and classify
  // the phase difference.
  function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] p;
    logic [1:0] c;
    logic [1:0] d;
    p = {prev[1], prev[1] ^ prev[0]};
    c = {cur[1], cur[1] ^ cur[0]};
    d = c - p;
    case (d)
      2'd0:    gray_step = STEP_NONE;
      2'd1:    gray_step = STEP_UP;
      2'd3:    gray_step = STEP_DN;
      default: gray_step = STEP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/accel_chan.sv
// One pickoff channel: previous phase, primed flag, wrapping accumulator and
// sticky illegal-transition flag, with read-and-clear that keeps the current step.
module accel_chan
  import accel_time_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    qual,
  input  logic                    halt,
  input  logic [1:0]              qr,
  input  logic                    clr,
  output logic signed [CNT_W-1:0] acc,
  output logic                    err
);

  logic [1:0]              prev;
  logic                    primed;
  step_e                   step;
  logic signed [CNT_W-1:0] delta;
  logic                    ill;

  always_comb begin
    step  = STEP_NONE;
    delta = '0;
    if (qual && primed) step = gray_step(prev, qr);
    case (step)
      STEP_UP: delta = {{(CNT_W-1){1'b0}}, 1'b1};
      STEP_DN: delta = '1;
      default: delta = '0;
    endcase
    ill = (step == STEP_ILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev   <= 2'b00;
      primed <= 1'b0;
      acc    <= '0;
      err    <= 1'b0;
    end else begin
      // Holding primed low for the whole halt forces a fresh prime on resume.
      if (halt) begin
        primed <= 1'b0;
      end else if (qual) begin
        prev   <= qr;
        primed <= 1'b1;
      end
      if (clr) begin
        acc <= delta;
        err <= ill;
      end else begin
        acc <= acc + delta;
        err <= err | ill;
      end
    end
  end

endmodule

// File: rtl/accel_time_proc_n.sv
// N-channel accelerometer pickoff processor: input synchronisers, halt status,
// per-channel step accumulators and a one-cycle read-and-clear port.
module accel_time_proc_n
  import accel_time_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = 12
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             SAMPLE,
  input  logic [N_CH-1:0]  Q,
  input  logic [N_CH-1:0]  R,
  input  logic             HLT,
  input  logic             RD_REQ,
  input  logic [2:0]       RD_CH,
  output logic             RD_ACK,
  output logic [CNT_W-1:0] RD_DATA,
  output logic             RD_ERR,
  output logic             HALT
);

  logic [N_CH-1:0]  q_p0, q_p1, r_p0, r_p1;
  logic             hlt_p0, hlt_p1;
  logic             qual;
  logic             sel_ok;
  logic [CNT_W-1:0] acc_arr [N_CH];
  logic [N_CH-1:0]  err_arr;
  logic [CNT_W-1:0] rd_data_nxt;
  logic             rd_err_nxt;

  // Stage p0/p1: two-flop synchronisers; HALT is one more register on top.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      q_p0   <= '0;
      q_p1   <= '0;
      r_p0   <= '0;
      r_p1   <= '0;
      hlt_p0 <= 1'b0;
      hlt_p1 <= 1'b0;
      HALT   <= 1'b0;
    end else begin
      q_p0   <= Q;
      q_p1   <= q_p0;
      r_p0   <= R;
      r_p1   <= r_p0;
      hlt_p0 <= HLT;
      hlt_p1 <= hlt_p0;
      HALT   <= hlt_p1;
    end
  end

  assign qual   = SAMPLE & ~HALT;
  assign sel_ok = ({29'd0, RD_CH} < 32'(N_CH));

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    accel_chan #(.CNT_W(CNT_W)) u_chan (
      .clk   (SIM_CLK),
      .rst_n (SIM_RST),
      .qual  (qual),
      .halt  (HALT),
      .qr    ({q_p1[g], r_p1[g]}),
      .clr   (RD_REQ && sel_ok && (RD_CH == 3'(g))),
      .acc   (acc_arr[g]),
      .err   (err_arr[g])
    );
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_err_nxt  = 1'b0;
    if (RD_REQ) begin
      if (sel_ok) begin
        for (int i = 0; i < N_CH; i++) begin
          if (RD_CH == 3'(i)) begin
            rd_data_nxt = acc_arr[i];
            rd_err_nxt  = err_arr[i];
          end
        end
      end else begin
        rd_err_nxt = 1'b1;
      end
    end
  end

  // Read response stage: outputs are zero whenever no acknowledge is issued.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      RD_ACK  <= 1'b0;
      RD_DATA <= '0;
      RD_ERR  <= 1'b0;
    end else begin
      RD_ACK  <= RD_REQ;
      RD_DATA <= rd_data_nxt;
      RD_ERR  <= rd_err_nxt;
    end
  end

endmodule

// File: tb/tb_accel_time_proc_n.sv
// Bench for accel_time_proc_n: step-decode table, directed corner sequences and
// a randomized run, all checked against a phase-index reference model.
module tb_accel_time_proc_n;

  localparam int NC = 3;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample = 1'b0;
  logic [NC-1:0] q = '0;
  logic [NC-1:0] r = '0;
  logic          hlt = 1'b0;
  logic          rd_req = 1'b0;
  logic [2:0]    rd_ch = '0;
  logic          rd_ack;
  logic [CW-1:0] rd_data;
  logic          rd_err;
  logic          halt;

  accel_time_proc_n #(.N_CH(NC), .CNT_W(CW)) dut (
    .SIM_CLK (clk),
    .SIM_RST (rst),
    .SAMPLE  (sample),
    .Q       (q),
    .R       (r),
    .HLT     (hlt),
    .RD_REQ  (rd_req),
    .RD_CH   (rd_ch),
    .RD_ACK  (rd_ack),
    .RD_DATA (rd_data),
    .RD_ERR  (rd_err),
    .HALT    (halt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Forward rotation order of {Q,R}.
  logic [1:0] gray [4];

  // Reference model state.
  logic [NC-1:0] mq1, mq2, mr1, mr2;
  logic          mh1, mh2, mhalt;
  logic [CW-1:0] mcnt [NC];
  int            mpos [NC];
  bit            mprimed [NC];
  bit            merr [NC];
  logic          exp_ack;
  logic [CW-1:0] exp_data;
  logic          exp_err;

  function automatic int pos_of(logic qv, logic rv);
    for (int k = 0; k < 4; k++) if (gray[k] == {qv, rv}) return k;
    return 0;
  endfunction

  task automatic model_clear();
    mq1 = '0; mq2 = '0; mr1 = '0; mr2 = '0;
    mh1 = 0; mh2 = 0; mhalt = 0;
    exp_ack = 0; exp_data = '0; exp_err = 0;
    for (int c = 0; c < NC; c++) begin
      mcnt[c] = '0; mpos[c] = 0; mprimed[c] = 0; merr[c] = 0;
    end
  endtask

  // Advance the model over one clock edge, clock the DUT, compare all outputs.
  task automatic tick();
    int d [NC];
    bit ill [NC];
    int cp, diff;
    if (!rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < NC; c++) begin
        d[c] = 0; ill[c] = 0;
        cp = pos_of(mq2[c], mr2[c]);
        if (sample && !mhalt) begin
          if (mprimed[c]) begin
            diff = (cp - mpos[c] + 4) % 4;
            if (diff == 1) d[c] = 1;
            else if (diff == 3) d[c] = -1;
            else if (diff == 2) ill[c] = 1;
          end
          mpos[c] = cp;
          mprimed[c] = 1;
        end
        if (mhalt) mprimed[c] = 0;
      end
      exp_ack = rd_req; exp_data = '0; exp_err = 0;
      if (rd_req) begin
        if (int'(rd_ch) < NC) begin
          exp_data = mcnt[rd_ch]; exp_err = merr[rd_ch];
        end else begin
          exp_err = 1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (rd_req && int'(rd_ch) == c) begin
          mcnt[c] = CW'(d[c]); merr[c] = ill[c];
        end else begin
          mcnt[c] = mcnt[c] + CW'(d[c]); merr[c] = merr[c] | ill[c];
        end
      end
      mhalt = mh2; mh2 = mh1; mh1 = hlt;
      mq2 = mq1; mq1 = q; mr2 = mr1; mr1 = r;
    end
    @(posedge clk); #1;
    vectors++;
    if (rd_ack !== exp_ack || rd_data !== exp_data || rd_err !== exp_err || halt !== mhalt) begin
      fails++;
      $display("FAIL model t=%0t ack %b want %b data %h want %h err %b want %b halt %b want %b",
               $time, rd_ack, exp_ack, rd_data, exp_data, rd_err, exp_err, halt, mhalt);
    end
  endtask

  task automatic check_out(string name, logic ack, logic [CW-1:0] data, logic err);
    vectors++;
    if (rd_ack !== ack || rd_data !== data || rd_err !== err) begin
      fails++;
      $display("FAIL %s ack %b want %b data %h want %h err %b want %b",
               name, rd_ack, ack, rd_data, data, rd_err, err);
    end
  endtask

  task automatic check_halt(string name, logic want);
    vectors++;
    if (halt !== want) begin
      fails++;
      $display("FAIL %s halt %b want %b", name, halt, want);
    end
  endtask

  task automatic do_reset();
    rst = 0; sample = 0; rd_req = 0; rd_ch = '0; hlt = 0; q = '0; r = '0;
    tick(); tick();
    rst = 1;
  endtask

  task automatic set_qr(int ch, logic [1:0] v);
    q[ch] = v[1]; r[ch] = v[0];
  endtask

  task automatic step(int ch, logic [1:0] v);
    set_qr(ch, v);
    tick(); tick();
    sample = 1; tick(); sample = 0;
  endtask

  task automatic do_read(int ch);
    rd_req = 1; rd_ch = 3'(ch); tick(); rd_req = 0;
  endtask

  typedef struct {
    logic [1:0]    prev;
    logic [1:0]    cur;
    logic [CW-1:0] data;
    logic          err;
  } vec_t;
  vec_t tbl [16];

  int pos1;
  int upos [NC];
  int sel;

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    tbl[0]  = '{2'b00, 2'b00, 12'h000, 1'b0};
    tbl[1]  = '{2'b00, 2'b01, 12'h001, 1'b0};
    tbl[2]  = '{2'b00, 2'b11, 12'h000, 1'b1};
    tbl[3]  = '{2'b00, 2'b10, 12'hFFF, 1'b0};
    tbl[4]  = '{2'b01, 2'b00, 12'hFFF, 1'b0};
    tbl[5]  = '{2'b01, 2'b01, 12'h000, 1'b0};
    tbl[6]  = '{2'b01, 2'b11, 12'h001, 1'b0};
    tbl[7]  = '{2'b01, 2'b10, 12'h000, 1'b1};
    tbl[8]  = '{2'b11, 2'b00, 12'h000, 1'b1};
    tbl[9]  = '{2'b11, 2'b01, 12'hFFF, 1'b0};
    tbl[10] = '{2'b11, 2'b11, 12'h000, 1'b0};
    tbl[11] = '{2'b11, 2'b10, 12'h001, 1'b0};
    tbl[12] = '{2'b10, 2'b00, 12'h001, 1'b0};
    tbl[13] = '{2'b10, 2'b01, 12'h000, 1'b1};
    tbl[14] = '{2'b10, 2'b11, 12'hFFF, 1'b0};
    tbl[15] = '{2'b10, 2'b10, 12'h000, 1'b0};
    model_clear();

    do_reset();
    check_out("reset_outputs", 1'b0, '0, 1'b0);
    check_halt("reset_halt", 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_reset();
      step(0, tbl[i].prev);
      step(0, tbl[i].cur);
      do_read(0);
      check_out($sformatf("decode_%0d", i), 1'b1, tbl[i].data, tbl[i].err);
    end

    // Full forward cycle on ch0, then read-and-clear.
    do_reset();
    step(0, 2'b00);
    step(0, 2'b01); step(0, 2'b11); step(0, 2'b10); step(0, 2'b00);
    do_read(0); check_out("fwd_cycle", 1'b1, 12'd4, 1'b0);
    do_read(0); check_out("fwd_reread", 1'b1, 12'd0, 1'b0);

    // Reverse on ch1, then wrap over 2^12+1 forward steps.
    step(1, 2'b00); step(1, 2'b10); step(1, 2'b11);
    do_read(1); check_out("reverse", 1'b1, 12'hFFE, 1'b0);
    pos1 = 2;
    for (int i = 0; i < 4097; i++) begin
      pos1 = (pos1 + 1) % 4;
      step(1, gray[pos1]);
    end
    do_read(1); check_out("wrap", 1'b1, 12'd1, 1'b0);

    // Illegal jump on ch2.
    step(2, 2'b00); step(2, 2'b11);
    do_read(2); check_out("illegal", 1'b1, 12'd0, 1'b1);
    do_read(2); check_out("illegal_clear", 1'b1, 12'd0, 1'b0);

    // Read coincident with a forward sample at acc=5.
    do_reset();
    step(0, 2'b00);
    for (int i = 1; i <= 5; i++) step(0, gray[i % 4]);
    set_qr(0, gray[2]); tick(); tick();
    sample = 1; rd_req = 1; rd_ch = 3'd0; tick(); sample = 0; rd_req = 0;
    check_out("coincident", 1'b1, 12'd5, 1'b0);
    do_read(0); check_out("coincident_next", 1'b1, 12'd1, 1'b0);

    // Halt: latency, ignored samples, re-prime on resume.
    do_reset();
    step(0, 2'b00);
    hlt = 1;
    tick(); check_halt("halt_lag1", 1'b0);
    tick(); check_halt("halt_lag2", 1'b0);
    tick(); check_halt("halt_lag3", 1'b1);
    step(0, 2'b01); step(0, 2'b11); step(0, 2'b10);
    do_read(0); check_out("halt_read", 1'b1, 12'd0, 1'b0);
    hlt = 0;
    tick(); tick(); check_halt("unhalt_lag2", 1'b1);
    tick(); check_halt("unhalt_lag3", 1'b0);
    step(0, 2'b10);
    step(0, 2'b00);
    do_read(0); check_out("resume", 1'b1, 12'd1, 1'b0);

    // Bad select, then reset colliding with a request.
    do_read(7); check_out("bad_sel", 1'b1, 12'd0, 1'b1);
    step(0, 2'b01);
    rd_req = 1; rd_ch = 3'd0; rst = 0; tick(); rd_req = 0; rst = 1;
    check_out("rst_drop", 1'b0, 12'd0, 1'b0);
    check_halt("rst_halt", 1'b0);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < NC; c++) upos[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) begin
        sel = $urandom_range(0, 99);
        if (sel < 15) upos[c] = (upos[c] + 1) % 4;
        else if (sel < 27) upos[c] = (upos[c] + 3) % 4;
        else if (sel < 30) upos[c] = (upos[c] + 2) % 4;
        set_qr(c, gray[upos[c]]);
      end
      sample = ($urandom_range(0, 2) == 0);
      rd_req = ($urandom_range(0, 3) == 0);
      rd_ch  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 149) == 0) hlt = ~hlt;
      rst = ($urandom_range(0, 699) != 0);
      tick();
    end
    rst = 1; sample = 0; rd_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/accel_time_proc_n.md
ACCEL_TIME_PROC_N -- requirements
Module: accel_time_proc_n

Interface
REQ-001 Parameter N_CH, default 3: number of accelerometer channels (X, Y, Z), range 1..8.
REQ-002 Parameter CNT_W, default 12: accumulator width per channel, range 4..26.
REQ-003 SIM_CLK  in  1  single system clock; all state changes on rising edge.
REQ-004 SIM_RST  in  1  reset, synchronous, active-low.
REQ-005 SAMPLE  in  1  one-cycle sample strobe (bit-time), asynchronous to nothing; already in SIM_CLK domain.
REQ-006 Q  in  N_CH  raw pickoff phase Q per channel, asynchronous.
REQ-007 R  in  N_CH  raw pickoff phase R per channel, asynchronous.
REQ-008 HLT  in  1  raw halt request, asynchronous.
REQ-009 RD_REQ  in  1  read-and-clear request, one cycle.
REQ-010 RD_CH  in  3  channel select qualified by RD_REQ.
REQ-011 RD_ACK  out  1  one-cycle read response valid.
REQ-012 RD_DATA  out  CNT_W  accumulated count of selected channel, two's complement.
REQ-013 RD_ERR  out  1  illegal-transition sticky flag of selected channel, or bad select.
REQ-014 HALT  out  1  synchronised halt status.

Function
REQ-015 Q, R and HLT SHALL each pass through a two-flop synchroniser; all further logic uses synchronised values only.
REQ-016 Each channel SHALL hold prev state {AQ,AR}, a primed bit, a CNT_W accumulator and a sticky error bit.
REQ-017 On SAMPLE with HALT=0 and primed=0, channel SHALL load {AQ,AR} from synchronised {Q,R}, set primed, no count.
REQ-018 On SAMPLE with HALT=0 and primed=1, step SHALL decode from {AQ,AR}->{Q,R}: forward Gray 00->01->11->10->00 = +1; reverse = -1; unchanged = 0; both bits changed = illegal.
REQ-019 Illegal step SHALL set the sticky error bit, not change the accumulator, and still update {AQ,AR}.
REQ-020 Accumulator SHALL add the step modulo 2^CNT_W (wrap, no saturation); {AQ,AR} updates on every qualified SAMPLE.
REQ-021 SAMPLE while HALT=1 SHALL be ignored; HALT rising SHALL clear primed in all channels so resumption re-primes.
REQ-022 HALT SHALL equal synchronised HLT, registered (total HLT->HALT latency 3 cycles).
REQ-023 RD_REQ with RD_CH<N_CH SHALL produce, next cycle, RD_ACK=1, RD_DATA=accumulator and RD_ERR=error bit as they stood in the request cycle.
REQ-024 In the request cycle the selected accumulator SHALL load that cycle's step (0 if none) and its error bit SHALL load that cycle's illegal indication; no count is lost.
REQ-025 RD_REQ with RD_CH>=N_CH SHALL give RD_ACK=1, RD_DATA=0, RD_ERR=1 next cycle, no state change.
REQ-026 Back-to-back RD_REQ every cycle SHALL be accepted; one ACK per REQ, fixed 1-cycle latency.
REQ-027 Reads SHALL be served regardless of HALT.
REQ-028 When RD_ACK=0, RD_DATA and RD_ERR SHALL be 0.

Reset
REQ-029 SIM_RST=0 at a clock edge SHALL clear synchronisers, {AQ,AR}, primed, accumulators, error bits, HALT, RD_ACK, RD_DATA, RD_ERR to 0.
REQ-030 Reset SHALL override SAMPLE and RD_REQ in the same cycle; a read in flight is dropped (no ACK).

Structure
REQ-031 Package accel_time_pkg SHALL hold the step enum (STEP_NONE, STEP_UP, STEP_DN, STEP_ILL) and the Gray-decode function.
REQ-032 Sub-module accel_chan SHALL implement one channel (REQ-016..021, 024), instantiated N_CH times by generate; top holds synchronisers, halt and read mux.

Verification
REQ-033 Reset, prime, then Q/R sequence 00,01,11,10,00 on five SAMPLEs -> read ch0 returns RD_DATA=4, RD_ERR=0; re-read returns 0.
REQ-034 Reverse sequence 00,10,11 on ch1 from zero, CNT_W=12 -> RD_DATA=0xFFE; 2^12+1 forward steps -> RD_DATA=1.
REQ-035 Ch2 jumps 00->11 -> RD_ERR=1, RD_DATA unchanged; second read -> RD_ERR=0.
REQ-036 RD_REQ ch0 coincident with a forward SAMPLE while acc=5 -> RD_DATA=5, following read returns 1.
REQ-037 HLT high, 3 forward steps, HLT low, SAMPLE, 1 forward step -> RD_DATA=1; HALT tracks HLT with 3-cycle lag.
REQ-038 RD_CH=7 with N_CH=3 -> RD_ACK=1, RD_DATA=0, RD_ERR=1; SIM_RST low mid-request -> no RD_ACK, all outputs 0.
